// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states and the
// {pc, instr} record held in the fetch buffer.
package fetch_pkg;
    localparam int          ILEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic {IDLE, RUN} fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  fetch_entry_t                 push_entry_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(BUF_DEPTH):0]   count_o,
    output fetch_entry_t                 head_o
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [BUF_DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_entry_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[head_q];
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, reads the combinational imem and
// queues {pc, instr} for decode; redirects flush the queue and restart fetch.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic          fetching;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          pop;
    logic          push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetching = 1'b0;
        case (state_q)
            RUN:     fetching = 1'b1;
            default: fetching = 1'b0;
        endcase
    end

    // A pop in a redirect cycle is a kill, not a transfer; the flush discards it.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    assign push = fetching & fetch_en & ~redirect_valid &
                  ((count < CW'(BUF_DEPTH)) | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = imem_instr;

    fetch_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (count),
        .head_o       (head)
    );

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: the imem model returns pc ^ DEADBEEF so
// every expected instruction word is derived from its expected PC.
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int vectors     = 0;
    int miscompares = 0;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = memWord(imem_addr);

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", out_pc); end
        vectors++;
        if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", out_instr); end
        vectors++;
        if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_stream();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_first_valid: got %b want 0", out_valid); end
        vectors++;
        if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_first_addr: got %h want 00000000", imem_addr); end
        step();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== memWord(32'(4 * i))) begin
                miscompares++;
                $display("FAIL stream_%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, out_valid, out_pc, out_instr, 32'(4 * i), memWord(32'(4 * i)));
            end
            step();
        end
    endtask

    task automatic test_stall();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_flush: got %b want 0", out_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== memWord(32'h0) ||
                imem_addr !== ((i == 0) ? 32'h4 : 32'h8)) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h addr=%h want v=1 pc=0 ins=%h addr=%h",
                         i, out_valid, out_pc, out_instr, imem_addr, memWord(32'h0), (i == 0) ? 32'h4 : 32'h8);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== memWord(32'(4 * i))) begin
                miscompares++;
                $display("FAIL stall_resume_%0d: got pc=%h ins=%h want pc=%h ins=%h",
                         i, out_pc, out_instr, 32'(4 * i), memWord(32'(4 * i)));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_bubble: got v=%b addr=%h want v=0 addr=00000100", out_valid, imem_addr);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== memWord(32'h100)) begin
            miscompares++;
            $display("FAIL redirect_target: got v=%b pc=%h ins=%h want v=1 pc=00000100 ins=%h",
                     out_valid, out_pc, out_instr, memWord(32'h100));
        end
        step();
        vectors++;
        if (out_pc !== 32'h104) begin miscompares++; $display("FAIL redirect_next: got %h want 00000104", out_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== memWord(exp_pc[i])) begin
                miscompares++;
                $display("FAIL wrap_%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, out_valid, out_pc, out_instr, exp_pc[i], memWord(exp_pc[i]));
            end
        end
    endtask

    task automatic test_fetch_en_drop();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        fetch_en = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || imem_addr !== 32'h208) begin
            miscompares++;
            $display("FAIL drop_held: got v=%b pc=%h addr=%h want v=1 pc=00000200 addr=00000208",
                     out_valid, out_pc, imem_addr);
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204 || imem_addr !== 32'h208) begin
            miscompares++;
            $display("FAIL drop_drain: got v=%b pc=%h addr=%h want v=1 pc=00000204 addr=00000208",
                     out_valid, out_pc, imem_addr);
        end
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h208) begin
            miscompares++;
            $display("FAIL drop_empty: got v=%b addr=%h want v=0 addr=00000208", out_valid, imem_addr);
        end
        fetch_en = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_restart_gap: got %b want 0", out_valid); end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_instr !== memWord(32'h208)) begin
            miscompares++;
            $display("FAIL drop_resume: got v=%b pc=%h ins=%h want v=1 pc=00000208 ins=%h",
                     out_valid, out_pc, out_instr, memWord(32'h208));
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h400) begin
            miscompares++;
            $display("FAIL b2b_bubble: got v=%b addr=%h want v=0 addr=00000400", out_valid, imem_addr);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            miscompares++;
            $display("FAIL b2b_target: got v=%b pc=%h want v=1 pc=00000400", out_valid, out_pc);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got %b want 1", out_valid); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_now: got v=%b pc=%h ins=%h addr=%h want all 0",
                     out_valid, out_pc, out_instr, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_restart: got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_fetch_en_drop();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
